sram_rr_arbiter: RTL and testbench

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

---
 rtl/sram_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Two-requester round-robin arbiter in front of a single-port synchronous SRAM.
//   The arbiter takes one command at a time from IDLE and runs it to completion:
//   IDLE -> CMD -> RESP for a write, and IDLE -> CMD -> RDWAIT -> RESP for a read.
//   A write completes 2 cycles after acceptance and a read completes 3 cycles after.
//   The next grant comes in the IDLE cycle that follows RESP.
//
// Ports
//   clk0                   clock; all state changes on its rising edge
//   rst0_n                 synchronous active-low reset
//   reqN_valid/_ready      command handshake for requester N (ready is a 1-cycle grant)
//   reqN_we/_addr/_wdata   command payload (we: 1 = write, 0 = read)
//   respN_valid            1-cycle completion pulse for requester N
//   respN_rdata            last read data returned to requester N (holds between reads)
//   csb0/web0              SRAM chip select and write enable (active-low)
//   addr0/din0             SRAM address and write data (0 when no command is driven)
//   dout0                  SRAM read data, valid the cycle after a read is sampled

module sram_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk0,
  input  logic                  rst0_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_rdata,

  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StRdWait,
    StResp
  } state_e;

  state_e                state_q, state_d;

  // Priority pointer: 0 favours requester 0, 1 favours requester 1 on a tie.
  logic                  ptr_q, ptr_d;

  // Registered command and the requester it belongs to.
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Per-requester read data, held until that requester's next read.
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  // Requester 1 wins when it is the only one asking, or on a tie when it holds priority.
  logic                  win1;
  logic                  any_valid;

  assign any_valid = req0_valid | req1_valid;
  assign win1      = req1_valid & (~req0_valid | ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    csb0        = 1'b1;
    web0        = 1'b1;
    addr0       = '0;
    din0        = '0;

    unique case (state_q)
      StIdle: begin
        // No grant while reset is asserted, so nothing is accepted and then lost.
        if (rst0_n && any_valid) begin
          req0_ready = ~win1;
          req1_ready = win1;
          gnt_d      = win1;
          we_d       = win1 ? req1_we    : req0_we;
          addr_d     = win1 ? req1_addr  : req0_addr;
          wdata_d    = win1 ? req1_wdata : req0_wdata;
          // Hand priority to whichever requester did not just win.
          ptr_d      = ~win1;
          state_d    = StCmd;
        end
      end

      StCmd: begin
        csb0    = 1'b0;
        web0    = ~we_q;
        addr0   = addr_q;
        din0    = wdata_q;
        state_d = we_q ? StResp : StRdWait;
      end

      StRdWait: begin
        // SRAM sampled the read on the previous edge; dout0 is valid now.
        if (gnt_q) begin
          rdata1_d = dout0;
        end else begin
          rdata0_d = dout0;
        end
        state_d = StResp;
      end

      StResp: begin
        // Suppress the pulse if reset lands in this cycle: the operation is aborted.
        resp0_valid = rst0_n & ~gnt_q;
        resp1_valid = rst0_n & gnt_q;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign resp0_rdata = rdata0_q;
  assign resp1_rdata = rdata1_q;

  // Invariants: at most one grant and at most one completion per cycle.
  a_ready_onehot: assert property (@(posedge clk0) !(req0_ready && req1_ready));
  a_resp_onehot:  assert property (@(posedge clk0) !(resp0_valid && resp1_valid));
  a_ready_rst:    assert property (@(posedge clk0) !rst0_n |-> !(req0_ready || req1_ready));

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural single-port SRAM behind it.
module tb_sram_rr_arbiter;

  logic        clk0;
  logic        rst0_n;
  logic [1:0]  vld;
  logic [1:0]  we;
  logic [6:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  wire  [1:0]  rdy;
  wire  [1:0]  rsp;
  wire  [31:0] rdata0;
  wire  [31:0] rdata1;
  wire         csb0;
  wire         web0;
  wire  [6:0]  addr0;
  wire  [31:0] din0;
  logic [31:0] dout0;
  logic [31:0] mem [128];

  int n_vec = 0;
  int n_err = 0;

  sram_rr_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(7)
  ) u_dut (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .req0_valid (vld[0]),
    .req0_ready (rdy[0]),
    .req0_we    (we[0]),
    .req0_addr  (req_addr[0]),
    .req0_wdata (req_wdata[0]),
    .resp0_valid(rsp[0]),
    .resp0_rdata(rdata0),
    .req1_valid (vld[1]),
    .req1_ready (rdy[1]),
    .req1_we    (we[1]),
    .req1_addr  (req_addr[1]),
    .req1_wdata (req_wdata[1]),
    .resp1_valid(rsp[1]),
    .resp1_rdata(rdata1),
    .csb0       (csb0),
    .web0       (web0),
    .addr0      (addr0),
    .din0       (din0),
    .dout0      (dout0)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Behavioural SRAM: samples on the rising edge, read data one cycle later.
  // A couple of words are preloaded while reset is held.
  always @(posedge clk0) begin
    if (!rst0_n) begin
      mem[5]  <= 32'h5555_0005;
      mem[63] <= 32'hDEAD_BEEF;
    end else if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else       dout0 <= mem[addr0];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  // Runs one command for requester id from IDLE to the following IDLE, checking
  // the grant, the SRAM bus in CMD, the completion pulse and (for reads) the data.
  task automatic issue(input int id, input logic w, input logic [6:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
    vld[id]       = 1'b1;
    we[id]        = w;
    req_addr[id]  = a;
    req_wdata[id] = d;
    @(negedge clk0);
    check_eq("grant", {62'b0, rdy}, (id == 0) ? 64'd1 : 64'd2);
    step();
    vld[id] = 1'b0;
    @(negedge clk0);
    check_eq("cmd_bus", {23'b0, csb0, web0, addr0, din0}, {23'b0, 1'b0, ~w, a, d});
    if (!w) begin
      step();
      @(negedge clk0);
      check_eq("rdwait_rsp", {62'b0, rsp}, 64'd0);
    end
    step();
    @(negedge clk0);
    check_eq("rsp", {62'b0, rsp}, (id == 0) ? 64'd1 : 64'd2);
    if (!w) check_eq("rdata", {32'b0, (id == 0) ? rdata0 : rdata1}, {32'b0, exp_rd});
    step();
  endtask

  initial begin
    int k;
    rst0_n       = 1'b0;
    vld          = 2'b11;
    we           = 2'b10;
    req_addr[0]  = 7'h3F;
    req_addr[1]  = 7'h3F;
    req_wdata[0] = 32'h0;
    req_wdata[1] = 32'h1234_5678;

    // Reset state, with both requesters already valid.
    step();
    step();
    @(negedge clk0);
    check_eq("rst_ready", {62'b0, rdy}, 64'd0);
    check_eq("rst_bus", {23'b0, csb0, web0, addr0, din0}, {23'b0, 1'b1, 1'b1, 7'd0, 32'd0});
    check_eq("rst_rsp", {62'b0, rsp}, 64'd0);
    check_eq("rst_rdata", {rdata1, rdata0}, 64'd0);

    // Tie from reset: req0 (read 0x3F) first, then req1 (write 0x3F).
    step();
    rst0_n = 1'b1;
    @(negedge clk0);
    check_eq("tie_gnt0", {62'b0, rdy}, 64'd1);
    step();
    vld[0] = 1'b0;
    @(negedge clk0);
    check_eq("tie_cmd0", {23'b0, csb0, web0, addr0, din0}, {23'b0, 1'b0, 1'b1, 7'h3F, 32'd0});
    check_eq("tie_busy_rdy", {62'b0, rdy}, 64'd0);
    step();
    step();
    @(negedge clk0);
    check_eq("tie_rsp0", {62'b0, rsp}, 64'd1);
    check_eq("tie_rdata0", {32'b0, rdata0}, 64'hDEAD_BEEF);
    step();
    @(negedge clk0);
    check_eq("tie_gnt1", {62'b0, rdy}, 64'd2);
    step();
    vld[1] = 1'b0;
    @(negedge clk0);
    check_eq("tie_cmd1", {23'b0, csb0, web0, addr0, din0}, {23'b0, 1'b0, 1'b0, 7'h3F, 32'h1234_5678});
    step();
    @(negedge clk0);
    check_eq("tie_rsp1", {62'b0, rsp}, 64'd2);
    step();

    // Continuous contention: grants must alternate, starting with req0.
    vld          = 2'b11;
    we           = 2'b11;
    req_addr[0]  = 7'd20;
    req_addr[1]  = 7'd21;
    req_wdata[0] = 32'h1111_1111;
    req_wdata[1] = 32'h2222_2222;
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      @(negedge clk0);
      if (rdy != 2'b00) begin
        check_eq("rr_gnt", {62'b0, rdy}, (k % 2 == 0) ? 64'd1 : 64'd2);
        k++;
      end
    end
    check_eq("rr_count", 64'(k), 64'd8);
    step();
    vld = 2'b00;
    step();
    step();

    // Write then read back from req0.
    issue(0, 1'b1, 7'd10, 32'hFACE_CAFE, 32'h0);
    issue(0, 1'b0, 7'd10, 32'h0, 32'hFACE_CAFE);

    // req1 read gives it a known rdata; then req1 writes 127 and req0 reads it.
    issue(1, 1'b0, 7'd10, 32'h0, 32'hFACE_CAFE);
    issue(1, 1'b1, 7'd127, 32'hA5A5_A5A5, 32'h0);
    issue(0, 1'b0, 7'd127, 32'h0, 32'hA5A5_A5A5);
    @(negedge clk0);
    check_eq("rdata1_hold", {32'b0, rdata1}, 64'hFACE_CAFE);
    check_eq("rdata0_hold", {32'b0, rdata0}, 64'hA5A5_A5A5);

    // Reset in RDWAIT of a req0 read to addr 5 (req0 grant leaves pointer on req1).
    step();
    vld[0]       = 1'b1;
    we[0]        = 1'b0;
    req_addr[0]  = 7'd5;
    req_wdata[0] = 32'h0;
    @(negedge clk0);
    check_eq("abort_gnt", {62'b0, rdy}, 64'd1);
    step();
    vld[0] = 1'b0;
    step();
    rst0_n = 1'b0;
    @(negedge clk0);
    check_eq("abort_rsp_rd", {62'b0, rsp}, 64'd0);
    step();
    rst0_n       = 1'b1;
    vld          = 2'b11;
    we           = 2'b11;
    req_addr[0]  = 7'd6;
    req_addr[1]  = 7'd7;
    req_wdata[0] = 32'h66;
    req_wdata[1] = 32'h77;
    @(negedge clk0);
    check_eq("abort_csb", {63'b0, csb0}, 64'd1);
    check_eq("abort_rsp", {62'b0, rsp}, 64'd0);
    check_eq("abort_rdata", {32'b0, rdata0}, 64'd0);
    check_eq("abort_ptr_gnt", {62'b0, rdy}, 64'd1);
    step();
    vld = 2'b00;
    step();
    @(negedge clk0);
    check_eq("abort_next_rsp", {62'b0, rsp}, 64'd1);
    step();

    // Idle bus for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk0);
      check_eq("idle_bus", {23'b0, csb0, web0, addr0, din0}, {23'b0, 1'b1, 1'b1, 7'd0, 32'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
